note_sequencer: RTL and testbench

Record/playback controller between the switch-to-note encoder and the tone generator.
- IDLE: passes the live 4-bit note code straight through.
- REC: run-length records the live note stream into an internal buffer, sampled on a timebase strobe.
- PLAY: replays the recorded sequence to the tone generator and ignores the live input.
- Single owner of the note bus feeding audio output.

---
 rtl/note_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller sitting between the switch-to-note
// encoder and the tone generator. It is the only driver of the note bus.
//   IDLE : live note passes through (one register of latency)
//   REC  : live note passes through, and on each tick it is run-length coded
//          into the buffer as {note, dur}
//   PLAY : recorded {note, dur} entries are replayed and live input is ignored
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   tick           one-cycle timebase strobe (sample / playback step)
//   live_note      note code from the switch encoder
//   rec_btn        pulse: start recording
//   play_btn       pulse: start playback
//   stop_btn       pulse: stop recording or playback
//   loop_en        level: playback wraps to entry 0 at the end of the sequence
//   note_out       registered note to the tone generator
//   recording      high in REC
//   playing        high in PLAY
//   full           high while rec_len == DEPTH
//   rec_len        number of valid recorded entries
module note_sequencer #(
  parameter int          ADDR_W    = 5,
  parameter int          DUR_W     = 4,
  parameter logic [3:0]  NOTE_NONE = 4'd0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              tick,
  input  logic [3:0]        live_note,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              loop_en,
  output logic [3:0]        note_out,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   rec_len
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [DUR_W-1:0] MAX_DUR = '1;

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr_ptr, wr_ptr_n;
  logic [ADDR_W-1:0]   rd_ptr, rd_ptr_n;
  logic [ADDR_W:0]     rec_len_n;
  logic                full_n;
  logic [3:0]          cur_note, cur_note_n;
  logic [DUR_W-1:0]    run_len, run_len_n;
  logic [DUR_W-1:0]    remaining, remaining_n;
  logic [3:0]          note_n;

  // Buffer: {note, dur}; not reset, only rec_len says what is valid.
  logic [DUR_W+3:0]    mem [DEPTH];
  logic                wr_en;
  logic [DUR_W+3:0]    entry0, entry_nx;
  logic [ADDR_W:0]     rd_cnt_nx;
  logic [ADDR_W:0]     rec_len_inc;

  assign rd_cnt_nx   = {1'b0, rd_ptr} + 1'b1;
  assign rec_len_inc = rec_len + 1'b1;
  assign entry0      = mem[0];
  assign entry_nx    = mem[rd_cnt_nx[ADDR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {cur_note, run_len};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_len   <= '0;
      full      <= 1'b0;
      cur_note  <= NOTE_NONE;
      run_len   <= '0;
      remaining <= '0;
      note_out  <= NOTE_NONE;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      rec_len   <= rec_len_n;
      full      <= full_n;
      cur_note  <= cur_note_n;
      run_len   <= run_len_n;
      remaining <= remaining_n;
      note_out  <= note_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    rec_len_n   = rec_len;
    full_n      = full;
    cur_note_n  = cur_note;
    run_len_n   = run_len;
    remaining_n = remaining;
    note_n      = live_note;
    wr_en       = 1'b0;
    case (state)
      S_IDLE: begin
        // stop has nothing to stop here, so it does not block rec/play
        if (rec_btn) begin
          state_n   = S_REC;
          wr_ptr_n  = '0;
          rec_len_n = '0;
          full_n    = 1'b0;
          run_len_n = '0;
        end else if (play_btn && rec_len != '0) begin
          state_n     = S_PLAY;
          rd_ptr_n    = '0;
          remaining_n = entry0[DUR_W-1:0];
          note_n      = entry0[DUR_W+3:DUR_W];
        end
      end
      S_REC: begin
        if (stop_btn) begin
          // a coincident tick is dropped; only the pending run is flushed
          if (run_len != '0 && rec_len < DEPTH_L) begin
            wr_en     = 1'b1;
            wr_ptr_n  = wr_ptr + 1'b1;
            rec_len_n = rec_len_inc;
            full_n    = (rec_len_inc == DEPTH_L);
          end
          run_len_n = '0;
          state_n   = S_IDLE;
        end else if (tick) begin
          if (run_len == '0) begin
            cur_note_n = live_note;
            run_len_n  = 1;
          end else if (live_note == cur_note && run_len < MAX_DUR) begin
            run_len_n = run_len + 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_ptr_n   = wr_ptr + 1'b1;
            rec_len_n  = rec_len_inc;
            cur_note_n = live_note;
            run_len_n  = 1;
            if (rec_len_inc == DEPTH_L) begin
              // buffer exhausted: the run just opened has nowhere to go
              full_n    = 1'b1;
              run_len_n = '0;
              state_n   = S_IDLE;
            end
          end
        end
      end
      S_PLAY: begin
        note_n = note_out;
        if (stop_btn) begin
          state_n = S_IDLE;
          note_n  = live_note;
        end else if (tick) begin
          if (remaining > 1) begin
            remaining_n = remaining - 1'b1;
          end else if (rd_cnt_nx < rec_len) begin
            rd_ptr_n    = rd_cnt_nx[ADDR_W-1:0];
            remaining_n = entry_nx[DUR_W-1:0];
            note_n      = entry_nx[DUR_W+3:DUR_W];
          end else if (loop_en) begin
            rd_ptr_n    = '0;
            remaining_n = entry0[DUR_W-1:0];
            note_n      = entry0[DUR_W+3:DUR_W];
          end else begin
            state_n = S_IDLE;
            note_n  = live_note;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign recording = (state == S_REC);
  assign playing   = (state == S_PLAY);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (default ADDR_W=5, DUR_W=4).
module tb_note_sequencer;
  logic       CLK = 1'b0;
  logic       RESET, tick, rec_btn, play_btn, stop_btn, loop_en;
  logic [3:0] live_note, note_out;
  logic       recording, playing, full;
  logic [5:0] rec_len;
  int         errors = 0;
  int         checks = 0;

  note_sequencer dut (
    .CLK(CLK), .RESET(RESET), .tick(tick), .live_note(live_note),
    .rec_btn(rec_btn), .play_btn(play_btn), .stop_btn(stop_btn),
    .loop_en(loop_en), .note_out(note_out), .recording(recording),
    .playing(playing), .full(full), .rec_len(rec_len)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic step_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_notes [6];
    logic       exp_play  [6];
    exp_notes = '{4'd3, 4'd3, 4'd7, 4'd7, 4'd0, 4'd9};
    exp_play  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    RESET = 1; tick = 0; rec_btn = 0; play_btn = 0; stop_btn = 0;
    loop_en = 0; live_note = 4'd0;
    cyc(2);
    chk("rst_note", 8'(note_out), 8'd0);
    chk("rst_len", 8'(rec_len), 8'd0);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_rec", 8'(recording), 8'd0);
    chk("rst_play", 8'(playing), 8'd0);
    RESET = 0;
    cyc();

    // passthrough with one cycle of latency
    live_note = 4'd5;
    chk("pass_before", 8'(note_out), 8'd0);
    cyc();
    chk("pass_after", 8'(note_out), 8'd5);
    chk("pass_rec", 8'(recording), 8'd0);
    chk("pass_play", 8'(playing), 8'd0);

    // play with empty buffer is ignored
    play_btn = 1; cyc(); play_btn = 0;
    chk("empty_play", 8'(playing), 8'd0);

    // rec beats play in the same cycle
    rec_btn = 1; play_btn = 1; cyc(); rec_btn = 0; play_btn = 0;
    chk("prio_rec", 8'(recording), 8'd1);
    chk("prio_play", 8'(playing), 8'd0);

    // record 3,3,3,7,7,0 -> {3,3},{7,2},{0,1}
    live_note = 4'd3; step_tick(); cyc();
    step_tick(); cyc();
    step_tick(); cyc();
    live_note = 4'd7; step_tick(); cyc();
    step_tick(); cyc();
    live_note = 4'd0; step_tick(); cyc();
    chk("rec_len_pre", 8'(rec_len), 8'd2);
    stop_btn = 1; cyc(); stop_btn = 0;
    chk("rec_len_stop", 8'(rec_len), 8'd3);
    chk("rec_off", 8'(recording), 8'd0);
    chk("rec_full", 8'(full), 8'd0);

    // replay: each tick edge shows the note the spec timing requires
    live_note = 4'd9; loop_en = 0;
    play_btn = 1; cyc(); play_btn = 0;
    chk("play_on", 8'(playing), 8'd1);
    chk("play_first", 8'(note_out), 8'd3);
    for (int i = 0; i < 6; i++) begin
      step_tick();
      chk($sformatf("play_note%0d", i), 8'(note_out), 8'(exp_notes[i]));
      chk($sformatf("play_st%0d", i), 8'(playing), 8'(exp_play[i]));
    end
    cyc();
    chk("play_end_live", 8'(note_out), 8'd9);
    chk("play_end_len", 8'(rec_len), 8'd3);

    // record {6,2} with a tick coincident with stop (not counted)
    rec_btn = 1; cyc(); rec_btn = 0;
    chk("rerec_len0", 8'(rec_len), 8'd0);
    live_note = 4'd6; step_tick(); step_tick();
    stop_btn = 1; tick = 1; cyc(); stop_btn = 0; tick = 0;
    chk("coinc_len", 8'(rec_len), 8'd1);
    play_btn = 1; cyc(); play_btn = 0;
    chk("coinc_note", 8'(note_out), 8'd6);
    step_tick();
    chk("coinc_t1", 8'(playing), 8'd1);
    step_tick();
    chk("coinc_t2", 8'(playing), 8'd0);

    // loop for 5 ticks then stop
    loop_en = 1; live_note = 4'd2;
    play_btn = 1; cyc(); play_btn = 0;
    for (int i = 0; i < 5; i++) begin
      step_tick();
      chk($sformatf("loop_note%0d", i), 8'(note_out), 8'd6);
      chk($sformatf("loop_st%0d", i), 8'(playing), 8'd1);
    end
    stop_btn = 1; cyc(); stop_btn = 0;
    chk("loop_stop", 8'(playing), 8'd0);
    chk("loop_stop_live", 8'(note_out), 8'd2);
    chk("loop_stop_len", 8'(rec_len), 8'd1);
    loop_en = 0;

    // run saturation: 16 ticks of note 4 -> {4,15},{4,1}
    rec_btn = 1; cyc(); rec_btn = 0;
    live_note = 4'd4;
    repeat (16) step_tick();
    chk("sat_len_pre", 8'(rec_len), 8'd1);
    stop_btn = 1; cyc(); stop_btn = 0;
    chk("sat_len", 8'(rec_len), 8'd2);
    live_note = 4'd8;
    play_btn = 1; cyc(); play_btn = 0;
    repeat (15) step_tick();
    chk("sat_t15_play", 8'(playing), 8'd1);
    chk("sat_t15_note", 8'(note_out), 8'd4);
    step_tick();
    chk("sat_t16_play", 8'(playing), 8'd0);
    cyc();
    chk("sat_live", 8'(note_out), 8'd8);

    // full: alternating 1,2 every tick, 32 writes need 33 ticks
    rec_btn = 1; cyc(); rec_btn = 0;
    for (int i = 0; i < 32; i++) begin
      live_note = (i % 2 == 0) ? 4'd1 : 4'd2;
      step_tick();
    end
    chk("full_len31", 8'(rec_len), 8'd31);
    chk("full_pre", 8'(full), 8'd0);
    chk("full_rec_pre", 8'(recording), 8'd1);
    live_note = 4'd1; step_tick();
    chk("full_len", 8'(rec_len), 8'd32);
    chk("full_flag", 8'(full), 8'd1);
    chk("full_idle", 8'(recording), 8'd0);
    live_note = 4'd2; step_tick(); step_tick();
    chk("full_hold_len", 8'(rec_len), 8'd32);
    chk("full_hold_flag", 8'(full), 8'd1);

    // play the full buffer, then async reset mid-play
    play_btn = 1; cyc(); play_btn = 0;
    chk("fplay_n0", 8'(note_out), 8'd1);
    step_tick();
    chk("fplay_n1", 8'(note_out), 8'd2);
    step_tick();
    chk("fplay_n2", 8'(note_out), 8'd1);
    RESET = 1; #1;
    chk("arst_note", 8'(note_out), 8'd0);
    chk("arst_len", 8'(rec_len), 8'd0);
    chk("arst_full", 8'(full), 8'd0);
    chk("arst_play", 8'(playing), 8'd0);
    RESET = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
